// File: rtl/rndgen_pkg.sv
// rtl/rndgen_pkg.sv - LFSR generator parameter sets and word arbiter state enum.
package rndgen_pkg;

  typedef struct packed {
    logic [6:0]  len;
    logic [63:0] taps;
  } RndGenParams_t;

  // XNOR-feedback polynomials: all-zero is a legal state, so reset to 0 works.
  localparam RndGenParams_t RndGen31 = '{len: 7'd31, taps: 64'h0000_0000_4800_0000};
  localparam RndGenParams_t RndGen15 = '{len: 7'd15, taps: 64'h0000_0000_0000_6000};

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ARB     = 2'd1,
    OFFER   = 2'd2
  } ArbState_t;

endpackage

// File: rtl/rnd_m.sv
// rtl/rnd_m.sv - Fibonacci XNOR LFSR, one serial bit per cycle.
module rnd_m
  import rndgen_pkg::*;
#(
  parameter RndGenParams_t PARAMS = RndGen31
) (
  input  logic clk,
  input  logic rst,
  output logic o_bit
);

  localparam int LEN = int'(PARAMS.len);
  localparam logic [63:0] MASK = (LEN >= 64) ? '1 : ((64'd1 << LEN) - 64'd1);

  logic [63:0] r_lfsr;
  logic        w_fb;

  assign w_fb  = ~^(r_lfsr & PARAMS.taps);
  assign o_bit = r_lfsr[LEN-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= '0;
    end else begin
      r_lfsr <= {r_lfsr[62:0], w_fb} & MASK;
    end
  end

endmodule

// File: rtl/rnd_word_arb.sv
// rtl/rnd_word_arb.sv - Collects W random bits into a word and hands it to a round-robin-selected requester.
module rnd_word_arb
  import rndgen_pkg::*;
#(
  parameter RndGenParams_t PARAMS = RndGen31,
  parameter int N_REQ = 4,
  parameter int W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             valid,
  output logic [W-1:0]     data,
  output logic [15:0]      words
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  ArbState_t     r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [W-2:0]  r_shreg, w_shreg;
  logic [W-1:0]  r_word, w_word;
  logic [PW-1:0] r_ptr, w_ptr;
  logic [PW-1:0] r_win, w_win;
  logic [15:0]   r_words, w_words;
  logic [W-1:0]  w_shift;
  logic          w_bit;

  rnd_m #(.PARAMS(PARAMS)) u_rnd (
    .clk  (clk),
    .rst  (rst),
    .o_bit(w_bit)
  );

  // First set bit at or after p, wrapping; lowest offset wins.
  function automatic logic [PW-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [PW-1:0] p);
    logic [PW-1:0] sel;
    int            idx;
    sel = p;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % N_REQ;
      if (r[idx]) sel = PW'(idx);
    end
    return sel;
  endfunction

  assign w_shift = {r_shreg, w_bit};

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_shreg = r_shreg;
    w_word  = r_word;
    w_ptr   = r_ptr;
    w_win   = r_win;
    w_words = r_words;
    case (r_state)
      COLLECT: begin
        w_shreg = w_shift[W-2:0];
        if (r_cnt == CW'(W - 1)) begin
          w_cnt   = '0;
          w_word  = w_shift;
          w_state = ARB;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      ARB: begin
        if (|req) begin
          w_win   = rr_pick(req, r_ptr);
          w_state = OFFER;
        end
      end
      OFFER: begin
        if (req[r_win]) begin
          w_words = r_words + 16'd1;
          w_ptr   = (r_win == PW'(N_REQ - 1)) ? '0 : r_win + 1'b1;
          w_state = COLLECT;
        end else begin
          w_state = ARB;
        end
      end
      default: w_state = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= COLLECT;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_word  <= '0;
      r_ptr   <= '0;
      r_win   <= '0;
      r_words <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_shreg <= w_shreg;
      r_word  <= w_word;
      r_ptr   <= w_ptr;
      r_win   <= w_win;
      r_words <= w_words;
    end
  end

  always_comb begin
    grant = '0;
    if (r_state == OFFER) grant[r_win] = 1'b1;
  end

  assign valid = (r_state == OFFER);
  assign data  = r_word;
  assign words = r_words;

endmodule

// File: tb/tb_rnd_word_arb.sv
// tb/tb_rnd_word_arb.sv - Randomized bench for rnd_word_arb against a sequence-level reference model.
module tb_rnd_word_arb;

  localparam int N = 4;
  localparam int W = 16;
  localparam int NB = 8192;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] grant;
  logic         valid;
  logic [W-1:0] data;
  logic [15:0]  words;

  always #5 clk = ~clk;

  rnd_word_arb #(.PARAMS(rndgen_pkg::RndGen31), .N_REQ(N), .W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .grant(grant),
    .valid(valid),
    .data (data),
    .words(words)
  );

  bit           b_seq[NB];
  int           e = 0;
  int           base = 0;
  int           t_start = 0;
  bit           m_off = 0;
  int           m_win = 0;
  int           m_ptr = 0;
  logic [15:0]  m_words = '0;
  logic [W-1:0] m_word = '0;
  int           n_tests = 0;
  int           n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, e);
    end
  endtask

  // Output bit n after reset: 31 zeros, then XNOR recurrence of x^31+x^28+1.
  function automatic void build_seq();
    for (int n = 0; n < NB; n++)
      b_seq[n] = (n < 31) ? 1'b0 : ~(b_seq[n-31] ^ b_seq[n-28]);
  endfunction

  function automatic logic [W-1:0] word_at(input int idx);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) w = {w[W-2:0], (idx + i < NB) ? b_seq[idx+i] : 1'b0};
    return w;
  endfunction

  function automatic int rr(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return p;
  endfunction

  function automatic int rel();
    return e - base;
  endfunction

  task automatic step(input logic [N-1:0] r, input logic rs);
    logic [N-1:0] g;
    req = r;
    rst = rs;
    e++;
    if (rs) begin
      base = e; t_start = e; m_off = 0; m_ptr = 0; m_words = '0; m_word = '0;
    end else begin
      if (m_off) begin
        m_off = 0;
        if (r[m_win]) begin
          m_words = m_words + 16'd1;
          m_ptr   = (m_win + 1) % N;
          t_start = e;
        end
      end else if (e >= t_start + W + 1 && r != '0) begin
        m_win = rr(r, m_ptr);
        m_off = 1;
      end
      if (e == t_start + W) m_word = word_at(t_start - base);
    end
    @(posedge clk);
    @(negedge clk);
    g = '0;
    if (m_off) g[m_win] = 1'b1;
    chk("valid", valid, m_off);
    chk("grant", grant, g);
    chk("data", data, m_word);
    chk("words", words, m_words);
  endtask

  task automatic do_reset();
    step('0, 1'b1);
    step('0, 1'b1);
  endtask

  logic [N-1:0] gq[$];
  int           eq[$];
  logic [N-1:0] exp_rr[5];
  logic [N-1:0] rnd_req;

  initial begin
    build_seq();
    exp_rr[0] = 4'b0001; exp_rr[1] = 4'b0010; exp_rr[2] = 4'b0100;
    exp_rr[3] = 4'b1000; exp_rr[4] = 4'b0001;
    @(negedge clk);

    // Single requester: first word at cycle 17, all zeros
    do_reset();
    chk("reset_words", words, 16'd0);
    for (int i = 0; i < 18; i++) begin
      step(4'b0001, 1'b0);
      if (valid) eq.push_back(rel());
      if (rel() == W + 1) begin
        chk("first_grant", grant, 4'b0001);
        chk("first_data", data, 16'h0000);
      end
    end
    chk("first_cnt", eq.size(), 1);
    if (eq.size() > 0) chk("first_cycle", eq[0], W + 1);
    chk("first_words", words, 16'd1);

    // All requesting: strict rotation every W+2 cycles
    do_reset();
    gq.delete(); eq.delete();
    for (int i = 0; i < 90; i++) begin
      step(4'b1111, 1'b0);
      if (valid) begin gq.push_back(grant); eq.push_back(rel()); end
    end
    chk("rr_count", gq.size(), 5);
    for (int i = 0; i < 5 && i < gq.size(); i++) begin
      chk("rr_grant", gq[i], exp_rr[i]);
      chk("rr_cycle", eq[i], W + 1 + i * (W + 2));
    end

    // ptr=2 after serving requester 1, then 1010 -> 3 before 1
    do_reset();
    gq.delete();
    for (int i = 0; i < 18; i++) step(4'b0010, 1'b0);
    for (int i = 0; i < 37; i++) begin
      step(4'b1010, 1'b0);
      if (valid) gq.push_back(grant);
    end
    chk("ptr_count", gq.size(), 2);
    if (gq.size() > 1) begin
      chk("ptr_first", gq[0], 4'b1000);
      chk("ptr_second", gq[1], 4'b0010);
    end

    // Request withdrawn during offer: no transfer, same word re-offered
    do_reset();
    for (int i = 0; i < 17; i++) step(4'b0001, 1'b0);
    chk("drop_offer", valid, 1'b1);
    step(4'b0000, 1'b0);
    chk("drop_valid", valid, 1'b0);
    chk("drop_words", words, 16'd0);
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0);
    step(4'b0001, 1'b0);
    chk("reoffer_valid", valid, 1'b1);
    chk("reoffer_data", data, 16'h0000);
    step(4'b0001, 1'b0);
    chk("reoffer_words", words, 16'd1);

    // Reset during offer discards the word
    do_reset();
    for (int i = 0; i < 17; i++) step(4'b0001, 1'b0);
    step(4'b0001, 1'b1);
    chk("rst_valid", valid, 1'b0);
    chk("rst_grant", grant, 4'b0000);
    chk("rst_words", words, 16'd0);
    for (int i = 0; i < 17; i++) step(4'b0001, 1'b0);
    chk("rst_reoffer", valid, 1'b1);
    chk("rst_redata", data, 16'h0000);
    step(4'b0001, 1'b0);

    // Word counter wraps
    dut.r_words = 16'hFFFF;
    m_words = 16'hFFFF;
    for (int i = 0; i < 18; i++) step(4'b0001, 1'b0);
    chk("wrap_words", words, 16'h0000);

    // Randomized requests with occasional resets
    rnd_req = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rnd_req = N'($urandom);
      step(rnd_req, ($urandom_range(0, 249) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rnd_word_arb.md
RND_WORD_ARB -- requirements
Module: rnd_word_arb

Interface
REQ-001 SHALL have parameter PARAMS: type rndgen_pkg::RndGenParams_t, default RndGen31; configures the LFSR.
REQ-002 SHALL have parameter N_REQ: int, default 4; number of requesters, range 2..16.
REQ-003 SHALL have parameter W: int, default 16; random word width, range 2..64.
REQ-004 SHALL have port clk, input, 1 bit: clock.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port req, input, N_REQ bits: level request, one bit per requester.
REQ-007 SHALL have port grant, output, N_REQ bits: one-hot grant, or zero.
REQ-008 SHALL have port valid, output, 1 bit: data holds a word for the granted requester.
REQ-009 SHALL have port data, output, W bits: random word.
REQ-010 SHALL have port words, output, 16 bits: count of delivered words, wraps modulo 2^16.

Function
REQ-011 SHALL instantiate one LFSR serial bit source that advances every cycle, independent of FSM state.
REQ-012 SHALL implement FSM states COLLECT, ARB and OFFER.
REQ-013 COLLECT SHALL shift shreg <= {shreg[W-2:0], lfsr_out} and increment cnt every cycle.
- When cnt==W-1: cnt<=0 and next state ARB; the word is then complete (first sampled bit = MSB).
REQ-014 LFSR bits produced in ARB and OFFER SHALL be discarded, not sampled.
REQ-015 ARB with req==0 SHALL hold the state and the word.
- With req!=0: register the round-robin winner (search starting at ptr, wrapping at N_REQ-1 -> 0) and go to OFFER.
REQ-016 OFFER SHALL drive valid=1, grant=onehot(winner) and data=word.
REQ-017 Transfer SHALL occur in an OFFER cycle where req[winner]=1.
- On transfer: words++, ptr<=(winner+1) mod N_REQ, next state COLLECT.
- valid is therefore a 1-cycle pulse.
REQ-018 If req[winner]=0 in OFFER: no transfer, word retained, ptr unchanged, next state ARB (re-arbitrate).
REQ-019 Outside OFFER, valid=0 and grant=0; data SHALL hold the last complete word (0 before the first).
REQ-020 Requests arriving during COLLECT SHALL only be considered at ARB; no request is lost while held.
REQ-021 Latency: rst deasserted before edge 1 -> COLLECT on edges 1..W, ARB decision on edge W+1, valid high during cycle W+1 (after edge W+1).
REQ-022 Steady state, with a requester always holding req: one word per W+2 cycles.
REQ-023 Simultaneous requests SHALL be served strictly round-robin; a requester waits at most N_REQ-1 words.

Reset
REQ-024 rst SHALL force: state=COLLECT, cnt=0, shreg=0, word=0, ptr=0, words=0, grant=0, valid=0, data=0, LFSR register=0.
REQ-025 rst SHALL take priority over any transfer in the same cycle; an in-flight word is discarded and not counted.
REQ-026 The post-reset word sequence SHALL be deterministic and identical on every reset.

Structure
REQ-027 RndGenParams_t and the RndGen* constants SHALL come from rndgen_pkg.
- The FSM state enum (ArbState_t) SHALL be added to rndgen_pkg.
REQ-028 The LFSR SHALL be the sub-module rnd_m (PARAMS passed through, clk/rst shared).
- No other sub-modules.
REQ-029 All state SHALL be in a single always_ff.
- Round-robin selection SHALL be a combinational function.

Verification
REQ-030 Reset, then req=4'b0001 held -> valid=1 and grant=4'b0001 in cycle 17 only; data=16'h0000 (RndGen31: first 31 LFSR bits are 0); words=1.
REQ-031 req=4'b1111 held -> grants 0001, 0010, 0100, 1000, 0001 in order, 18 cycles apart.
REQ-032 ptr=2 (after serving requester 1), req=4'b1010 -> grant=4'b1000 first, then 4'b0010.
REQ-033 req[0] dropped in the cycle of ARB->OFFER -> no transfer, words unchanged; req[0] reasserted -> same data value delivered, no new COLLECT.
REQ-034 rst pulsed during OFFER -> valid=0 and grant=0 the next cycle, words=0; the next delivered word again equals 16'h0000 at cycle 17 after release.
REQ-035 Force words=16'hFFFF, then one transfer -> words=16'h0000.
